prog_loader: RTL and testbench

- Writer side of the CPU's instruction/data memory: takes a byte stream over a valid/ready handshake and writes it into the byte-wide `mem` array that the CPU fetches from.
- Holds the CPU in reset (`cpu_run` low) until a complete image is loaded, then releases it.
- Sits between the host/bench byte source and the memory write port, alongside the core.

---
 rtl/prog_loader_pkg.sv | 35 +++
 rtl/prog_loader.sv | 148 ++++++++++++++
 tb/tb_prog_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared constants for the program loader: data/address widths, the
// LDR_S_* 3-bit state encodings and the FSM state type built from them.
// Optional feature macro used by the loader: PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int LDR_WIDTH_WORD   = 8;
  localparam int LDR_WIDTH_DOUBLE = 16;

  localparam logic [2:0] LDR_S_ALO  = 3'd0;
  localparam logic [2:0] LDR_S_AHI  = 3'd1;
  localparam logic [2:0] LDR_S_LLO  = 3'd2;
  localparam logic [2:0] LDR_S_LHI  = 3'd3;
  localparam logic [2:0] LDR_S_DATA = 3'd4;
  localparam logic [2:0] LDR_S_CSUM = 3'd5;
  localparam logic [2:0] LDR_S_DONE = 3'd6;
  localparam logic [2:0] LDR_S_ERR  = 3'd7;

  typedef enum logic [2:0] {
    S_ALO  = LDR_S_ALO,
    S_AHI  = LDR_S_AHI,
    S_LLO  = LDR_S_LLO,
    S_LHI  = LDR_S_LHI,
    S_DATA = LDR_S_DATA,
    S_CSUM = LDR_S_CSUM,
    S_DONE = LDR_S_DONE,
    S_ERR  = LDR_S_ERR
  } ldr_state_e;

  // The loader takes bytes in every state except the two terminal ones.
  function automatic logic ldr_accepting(input ldr_state_e s);
    return (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader
// Receives a little-endian frame over a valid/ready byte stream
// (ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, optional CSUM)
// and writes the payload into the CPU's byte-wide memory. The CPU is
// held (cpu_run low) until the whole image has been written.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to expect a trailing
// 8-bit modular-sum checksum byte; a mismatch ends in S_ERR with err=1.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   byte stream handshake, in_data is the byte
//   start               re-arm pulse, honoured only in S_DONE/S_ERR
//   mem_we/addr/wdata   registered memory write port, one strobe per byte
//   cpu_run             high once the image is loaded
//   entry               load base address, initial PC for the CPU
//   err                 checksum mismatch (tied 0 without the feature)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH_WORD   = LDR_WIDTH_WORD,
  parameter int WIDTH_DOUBLE = LDR_WIDTH_DOUBLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_WORD-1:0]   in_data,
  input  logic                    start,
  output logic                    mem_we,
  output logic [WIDTH_DOUBLE-1:0] mem_addr,
  output logic [WIDTH_WORD-1:0]   mem_wdata,
  output logic                    cpu_run,
  output logic [WIDTH_DOUBLE-1:0] entry,
  output logic                    err
);

  ldr_state_e              state;
  logic [WIDTH_DOUBLE-1:0] count;
  logic [WIDTH_DOUBLE-1:0] cur;
  logic                    accept;

  // Memory never stalls, so readiness depends only on the state; it is
  // forced low while reset is asserted.
  assign in_ready = rst_n && ldr_accepting(state);
  assign accept   = in_valid && in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH_WORD-1:0] sum;
  logic                  err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Loader FSM with the byte counter, write address and all outputs
  // registered. The base address is assembled in cur, which then walks
  // through the payload and wraps naturally at the top of memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ALO;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      entry     <= '0;
      count     <= '0;
      cur       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_ALO: if (accept) begin
          cur[WIDTH_WORD-1:0] <= in_data;
          state               <= S_AHI;
        end
        S_AHI: if (accept) begin
          cur[WIDTH_DOUBLE-1:WIDTH_WORD] <= in_data;
          entry                          <= {in_data, cur[WIDTH_WORD-1:0]};
          state                          <= S_LLO;
        end
        S_LLO: if (accept) begin
          count[WIDTH_WORD-1:0] <= in_data;
          state                 <= S_LHI;
        end
        S_LHI: if (accept) begin
          count[WIDTH_DOUBLE-1:WIDTH_WORD] <= in_data;
          if ({in_data, count[WIDTH_WORD-1:0]} == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state   <= S_CSUM;
`else
            state   <= S_DONE;
            cpu_run <= 1'b1;
`endif
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (accept) begin
          mem_we    <= 1'b1;
          mem_addr  <= cur;
          mem_wdata <= in_data;
          cur       <= cur + WIDTH_DOUBLE'(1);
          count     <= count - WIDTH_DOUBLE'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum       <= sum + in_data;
`endif
          // cpu_run rises on the same edge as the last write strobe.
          if (count == WIDTH_DOUBLE'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state   <= S_CSUM;
`else
            state   <= S_DONE;
            cpu_run <= 1'b1;
`endif
          end
        end
        S_CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (accept) begin
            if (in_data == sum) begin
              state   <= S_DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= S_ERR;
              err_q <= 1'b1;
            end
          end
`endif
        end
        S_DONE, S_ERR: if (start) begin
          state   <= S_ALO;
          cpu_run <= 1'b0;
          count   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum     <= '0;
          err_q   <= 1'b0;
`endif
        end
        default: state <= S_ALO;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed frames for prog_loader. Expected memory writes are queued as
// bytes are issued; a negedge monitor pops and compares every mem_we
// strobe, and flags any strobe that arrives with nothing expected.
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        start;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_run;
  logic [15:0] entry;
  logic        err;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  pl[16];

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .entry(entry), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_we", {31'd0, mem_we}, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        checkOutput("write_addr", {16'd0, mem_addr}, {16'd0, e[23:8]});
        checkOutput("write_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] b, input bit is_payload,
                               input logic [15:0] waddr);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (is_payload) exp_q.push_back({waddr, b});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic load_frame(input logic [15:0] base, input int len,
                            input logic [7:0] csum_flip, input int stall_at);
    logic [7:0]  s;
    logic [15:0] a;
    logic [15:0] l16;
    s   = 8'h00;
    a   = base;
    l16 = len[15:0];
    applyStimulus(base[7:0], 1'b0, 16'h0);
    applyStimulus(base[15:8], 1'b0, 16'h0);
    applyStimulus(l16[7:0], 1'b0, 16'h0);
    applyStimulus(l16[15:8], 1'b0, 16'h0);
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      applyStimulus(pl[i], 1'b1, a);
      s = s + pl[i];
      a = a + 16'd1;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(s ^ csum_flip, 1'b0, 16'h0);
`else
    s = s ^ csum_flip;
`endif
  endtask

  task automatic drain_check(input string name);
    @(negedge clk); #1;
    checkOutput(name, exp_q.size(), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_cpu_run", {31'd0, cpu_run}, 32'd0);
    checkOutput("restart_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    checkOutput("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    checkOutput("rst_entry", {16'd0, entry}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // MVC/MVC/ADD program at 0x0006.
    pl[0] = 8'h08; pl[1] = 8'hC1; pl[2] = 8'h05;
    pl[3] = 8'hC3; pl[4] = 8'h12; pl[5] = 8'h83;
    load_frame(16'h0006, 6, 8'h00, -1);
    checkOutput("prog_entry", {16'd0, entry}, 32'h0006);
    checkOutput("prog_cpu_run", {31'd0, cpu_run}, 32'd1);
    checkOutput("prog_err", {31'd0, err}, 32'd0);
    drain_check("prog_writes_done");

    // Bytes offered in S_DONE must be refused and never written.
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("done_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("done_cpu_run", {31'd0, cpu_run}, 32'd1);
    in_valid = 1'b0;
    pulse_start();

    // Empty image.
    load_frame(16'h1234, 0, 8'h00, -1);
    checkOutput("len0_cpu_run", {31'd0, cpu_run}, 32'd1);
    checkOutput("len0_entry", {16'd0, entry}, 32'h1234);
    drain_check("len0_no_writes");
    pulse_start();

    // Address wrap from 0xFFFF to 0x0000.
    pl[0] = 8'hAA; pl[1] = 8'h55;
    load_frame(16'hFFFF, 2, 8'h00, -1);
    checkOutput("wrap_cpu_run", {31'd0, cpu_run}, 32'd1);
    checkOutput("wrap_entry", {16'd0, entry}, 32'hFFFF);
    drain_check("wrap_writes_done");
    pulse_start();

    // Three idle cycles in the middle of the payload.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    load_frame(16'h0100, 4, 8'h00, 2);
    checkOutput("stall_cpu_run", {31'd0, cpu_run}, 32'd1);
    drain_check("stall_writes_done");
    pulse_start();

`ifdef PROG_LOADER_CHECKSUM_EN
    pl[0] = 8'hAA; pl[1] = 8'h55;
    load_frame(16'h0040, 2, 8'h00, -1);
    checkOutput("csum_ok_cpu_run", {31'd0, cpu_run}, 32'd1);
    checkOutput("csum_ok_err", {31'd0, err}, 32'd0);
    drain_check("csum_ok_writes");
    pulse_start();
    load_frame(16'h0040, 2, 8'h01, -1);
    checkOutput("csum_bad_err", {31'd0, err}, 32'd1);
    checkOutput("csum_bad_cpu_run", {31'd0, cpu_run}, 32'd0);
    checkOutput("csum_bad_ready", {31'd0, in_ready}, 32'd0);
    drain_check("csum_bad_writes");
    pulse_start();
    checkOutput("csum_restart_err", {31'd0, err}, 32'd0);
`endif

    // Reset after three payload bytes aborts the load.
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    applyStimulus(8'h00, 1'b0, 16'h0);
    applyStimulus(8'h02, 1'b0, 16'h0);
    applyStimulus(8'h06, 1'b0, 16'h0);
    applyStimulus(8'h00, 1'b0, 16'h0);
    applyStimulus(pl[0], 1'b1, 16'h0200);
    applyStimulus(pl[1], 1'b1, 16'h0201);
    applyStimulus(pl[2], 1'b1, 16'h0202);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("abort_cpu_run", {31'd0, cpu_run}, 32'd0);
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("abort_writes", exp_q.size(), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh full frame after the abort.
    pl[0] = 8'h08; pl[1] = 8'hC1; pl[2] = 8'h05;
    pl[3] = 8'hC3; pl[4] = 8'h12; pl[5] = 8'h83;
    load_frame(16'h0300, 6, 8'h00, -1);
    checkOutput("reload_entry", {16'd0, entry}, 32'h0300);
    checkOutput("reload_cpu_run", {31'd0, cpu_run}, 32'd1);
    drain_check("reload_writes_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
